// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline segment controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Controller modes: post-reset drain, normal flow, fetch miss, data miss
  typedef enum logic [1:0] {
    ST_DRAIN = 2'd0,
    ST_RUN   = 2'd1,
    ST_IMISS = 2'd2,
    ST_DMISS = 2'd3
  } seg_state_e;

  // Field positions inside RegReadD
  localparam int REGRD_RS1_BIT = 1;
  localparam int REGRD_RS2_BIT = 0;

  // Bit positions inside the 5-bit per-segment stall/flush vectors
  localparam int SEG_F = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_M = 1;
  localparam int SEG_W = 0;

  // Default number of all-flush cycles after reset
  localparam int RST_DRAIN_DEF = 3;

  // True when the ID instruction reads the register an EX load is about to write.
  // x0 never creates a dependency since it is hardwired to zero.
  function automatic logic load_use_hit(
    input logic       mem_rd,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic [1:0] regrd
  );
    return mem_rd && (rd != 5'd0) &&
           ((regrd[REGRD_RS1_BIT] && (rs1 == rd)) ||
            (regrd[REGRD_RS2_BIT] && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipeline_seg_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count visible one clock after the increment request.
// Backpressure: none; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority; otherwise count up until every bit is set
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_seg_ctrl.sv
// Stall/flush sequencer for the IF/ID/EX/MEM/WB segment registers, with perf counters.
// Latency: Stall/Flush are combinational from state and inputs; state and counters move on clk.
// Backpressure: cache misses hold the upstream segments; stall and flush never hit one segment together.
module pipeline_seg_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RST_DRAIN = RST_DRAIN_DEF,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             CpuRst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [1:0]       RegReadD,
  input  logic [4:0]       RdE,
  input  logic             MemReadE,
  input  logic             RedirectE,
  input  logic             JalD,
  input  logic             ICacheMiss,
  input  logic             DCacheMiss,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushF,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int DRAIN_W = (RST_DRAIN > 2) ? $clog2(RST_DRAIN) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(RST_DRAIN - 1);

  seg_state_e         r_state;
  seg_state_e         w_state_nxt;
  seg_state_e         w_mode;
  logic [DRAIN_W-1:0] r_drain;
  logic [DRAIN_W-1:0] w_drain_nxt;
  logic               r_redir_pend;
  logic               w_redir_pend_nxt;
  logic [4:0]         w_stall;
  logic [4:0]         w_flush;
  logic               w_redir_evt;
  logic               w_load_use;
  logic               w_any_stall;

  assign w_load_use = load_use_hit(MemReadE, RdE, Rs1D, Rs2D, RegReadD);

  // Once a data miss clears, that same cycle behaves like the mode it returns to:
  // fetch-miss handling if a redirect is still owed to ID, plain run otherwise.
  assign w_mode = ((r_state == ST_DMISS) && !DCacheMiss)
                ? (r_redir_pend ? ST_IMISS : ST_RUN)
                : r_state;

  // Sequencer register: mode, drain countdown and the owed-redirect flag
  always_ff @(posedge clk) begin
    if (CpuRst) begin
      r_state      <= ST_DRAIN;
      r_drain      <= DRAIN_INIT;
      r_redir_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_drain      <= w_drain_nxt;
      r_redir_pend <= w_redir_pend_nxt;
    end
  end

  // Next mode and per-segment stall/flush for this cycle
  always_comb begin
    w_state_nxt      = r_state;
    w_drain_nxt      = r_drain;
    w_redir_pend_nxt = r_redir_pend;
    w_stall          = 5'b00000;
    w_flush          = 5'b00000;
    w_redir_evt      = 1'b0;

    case (w_mode)
      ST_DRAIN: begin
        // Flush everything while the pipe fills with known bubbles
        w_flush = 5'b11111;
        if (r_drain == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_drain_nxt = r_drain - 1'b1;
        end
      end

      ST_RUN: begin
        w_state_nxt = ST_RUN;
        if (DCacheMiss) begin
          // MEM is blocked: freeze F..M, drop a bubble into WB
          w_stall[SEG_F] = 1'b1;
          w_stall[SEG_D] = 1'b1;
          w_stall[SEG_E] = 1'b1;
          w_stall[SEG_M] = 1'b1;
          w_flush[SEG_W] = 1'b1;
          w_state_nxt    = ST_DMISS;
        end else if (RedirectE) begin
          // Wrong-path instructions sit in ID and IF->ID; kill both
          w_flush[SEG_D] = 1'b1;
          w_flush[SEG_E] = 1'b1;
          w_redir_evt    = 1'b1;
          if (ICacheMiss) begin
            // The missing fetch is wrong-path; remember to squash it on arrival
            w_stall[SEG_F]   = 1'b1;
            w_redir_pend_nxt = 1'b1;
            w_state_nxt      = ST_IMISS;
          end
        end else begin
          if (w_load_use) begin
            w_stall[SEG_F] = 1'b1;
            w_stall[SEG_D] = 1'b1;
            w_flush[SEG_E] = 1'b1;
          end else if (JalD) begin
            w_flush[SEG_D] = 1'b1;
            w_redir_evt    = 1'b1;
          end
          if (ICacheMiss) begin
            // Nothing valid to hand to ID; the load-use hold on ID wins over a bubble
            w_stall[SEG_F] = 1'b1;
            if (!w_load_use) begin
              w_flush[SEG_D] = 1'b1;
            end
            w_state_nxt = ST_IMISS;
          end
        end
      end

      ST_IMISS: begin
        w_state_nxt = ST_IMISS;
        if (DCacheMiss) begin
          w_stall[SEG_F] = 1'b1;
          w_stall[SEG_D] = 1'b1;
          w_stall[SEG_E] = 1'b1;
          w_stall[SEG_M] = 1'b1;
          w_flush[SEG_W] = 1'b1;
          w_state_nxt    = ST_DMISS;
        end else if (ICacheMiss) begin
          // Fetch still waiting: hold IF, feed bubbles to ID, let EX..WB run
          w_stall[SEG_F] = 1'b1;
          w_flush[SEG_D] = 1'b1;
          if (RedirectE) begin
            w_flush[SEG_E]   = 1'b1;
            w_redir_evt      = 1'b1;
            w_redir_pend_nxt = 1'b1;
          end else if (w_load_use) begin
            w_stall[SEG_D] = 1'b1;
            w_flush[SEG_D] = 1'b0;
            w_flush[SEG_E] = 1'b1;
          end else if (JalD) begin
            w_redir_evt      = 1'b1;
            w_redir_pend_nxt = 1'b1;
          end
        end else begin
          // Fetch returns: squash it if a redirect happened while it was in flight
          w_state_nxt      = ST_RUN;
          w_redir_pend_nxt = 1'b0;
          w_flush[SEG_D]   = r_redir_pend;
          if (RedirectE) begin
            w_flush[SEG_D] = 1'b1;
            w_flush[SEG_E] = 1'b1;
            w_redir_evt    = 1'b1;
          end else if (w_load_use) begin
            w_stall[SEG_F] = 1'b1;
            w_stall[SEG_D] = 1'b1;
            w_flush[SEG_D] = 1'b0;
            w_flush[SEG_E] = 1'b1;
          end else if (JalD) begin
            w_flush[SEG_D] = 1'b1;
            w_redir_evt    = 1'b1;
          end
        end
      end

      ST_DMISS: begin
        // Only reached while DCacheMiss is still high; nothing else may act
        w_stall[SEG_F] = 1'b1;
        w_stall[SEG_D] = 1'b1;
        w_stall[SEG_E] = 1'b1;
        w_stall[SEG_M] = 1'b1;
        w_flush[SEG_W] = 1'b1;
      end

      default: begin
        w_state_nxt = ST_DRAIN;
        w_drain_nxt = DRAIN_INIT;
      end
    endcase
  end

  assign StallF = w_stall[SEG_F];
  assign StallD = w_stall[SEG_D];
  assign StallE = w_stall[SEG_E];
  assign StallM = w_stall[SEG_M];
  assign StallW = w_stall[SEG_W];
  assign FlushF = w_flush[SEG_F];
  assign FlushD = w_flush[SEG_D];
  assign FlushE = w_flush[SEG_E];
  assign FlushM = w_flush[SEG_M];
  assign FlushW = w_flush[SEG_W];

  assign w_any_stall = |w_stall;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (clk),
    .i_clear (CpuRst),
    .i_inc   (w_any_stall),
    .o_cnt   (StallCnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .i_clk   (clk),
    .i_clear (CpuRst),
    .i_inc   (w_redir_evt),
    .o_cnt   (FlushCnt)
  );

endmodule

// File: tb/tb_pipeline_seg_ctrl.sv
// Self-checking bench for pipeline_seg_ctrl: directed scenarios plus randomized traffic.
// Latency: compares combinational outputs mid-cycle, counters one cycle after events.
// Backpressure: n/a.
module tb_pipeline_seg_ctrl;

  localparam int TB_DRAIN = 3;
  localparam int TB_CW    = 10;
  localparam int CNT_MAX  = (1 << TB_CW) - 1;

  logic              clk = 1'b0;
  logic              CpuRst;
  logic [4:0]        Rs1D, Rs2D, RdE;
  logic [1:0]        RegReadD;
  logic              MemReadE, RedirectE, JalD, ICacheMiss, DCacheMiss;
  logic              StallF, StallD, StallE, StallM, StallW;
  logic              FlushF, FlushD, FlushE, FlushM, FlushW;
  logic [TB_CW-1:0]  StallCnt, FlushCnt;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_seg_ctrl #(
    .RST_DRAIN (TB_DRAIN),
    .CNT_W     (TB_CW)
  ) dut (
    .clk        (clk),
    .CpuRst     (CpuRst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RegReadD   (RegReadD),
    .RdE        (RdE),
    .MemReadE   (MemReadE),
    .RedirectE  (RedirectE),
    .JalD       (JalD),
    .ICacheMiss (ICacheMiss),
    .DCacheMiss (DCacheMiss),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .StallW     (StallW),
    .FlushF     (FlushF),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushM     (FlushM),
    .FlushW     (FlushW),
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Modes: 0 = draining after reset, 1 = running, 2 = waiting on fetch, 3 = waiting on data
  int         m_mode  = 0;
  int         m_drain = TB_DRAIN - 1;
  bit         m_pend  = 1'b0;
  int         m_scnt  = 0;
  int         m_fcnt  = 0;
  int         n_mode, n_drain;
  bit         n_pend;
  logic [4:0] e_stall, e_flush;   // bit4 = IF ... bit0 = WB
  bit         e_evt;

  function automatic logic [9:0] dut_vec();
    return {StallF, StallD, StallE, StallM, StallW, FlushF, FlushD, FlushE, FlushM, FlushW};
  endfunction

  task automatic model_eval();
    bit lu, fetch_wait;
    lu = MemReadE && (RdE != 0) &&
         ((RegReadD[1] && Rs1D == RdE) || (RegReadD[0] && Rs2D == RdE));
    e_stall = 5'b0; e_flush = 5'b0; e_evt = 0;
    n_mode = m_mode; n_drain = m_drain; n_pend = m_pend;
    if (m_mode == 0) begin
      e_flush = 5'b11111;
      if (m_drain == 0) n_mode = 1; else n_drain = m_drain - 1;
    end else if (DCacheMiss) begin
      e_stall = 5'b11110; e_flush = 5'b00001; n_mode = 3;
    end else begin
      fetch_wait = (m_mode == 2) || (m_mode == 3 && m_pend);
      if (!fetch_wait) begin
        n_mode = 1;
        if (RedirectE) begin
          e_flush = 5'b01100; e_evt = 1;
          if (ICacheMiss) begin e_stall[4] = 1; n_pend = 1; n_mode = 2; end
        end else begin
          if (lu) begin e_stall = 5'b11000; e_flush = 5'b00100; end
          else if (JalD) begin e_flush = 5'b01000; e_evt = 1; end
          if (ICacheMiss) begin
            e_stall[4] = 1;
            if (!lu) e_flush[3] = 1;
            n_mode = 2;
          end
        end
      end else if (ICacheMiss) begin
        n_mode = 2; e_stall = 5'b10000; e_flush = 5'b01000;
        if (RedirectE) begin e_flush[2] = 1; e_evt = 1; n_pend = 1; end
        else if (lu) begin e_stall[3] = 1; e_flush = 5'b00100; end
        else if (JalD) begin e_evt = 1; n_pend = 1; end
      end else begin
        n_mode = 1; n_pend = 0; e_flush[3] = m_pend;
        if (RedirectE) begin e_flush = 5'b01100; e_evt = 1; end
        else if (lu) begin e_stall = 5'b11000; e_flush = 5'b00100; end
        else if (JalD) begin e_flush[3] = 1; e_evt = 1; end
      end
    end
  endtask

  // Finish the current cycle: model follows the DUT across the rising edge
  task automatic advance();
    model_eval();
    @(posedge clk);
    if (CpuRst) begin
      m_mode = 0; m_drain = TB_DRAIN - 1; m_pend = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (e_stall != 0 && m_scnt < CNT_MAX) m_scnt++;
      if (e_evt && m_fcnt < CNT_MAX) m_fcnt++;
      m_mode = n_mode; m_drain = n_drain; m_pend = n_pend;
    end
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; RdE = 0; RegReadD = 0; MemReadE = 0;
    RedirectE = 0; JalD = 0; ICacheMiss = 0; DCacheMiss = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    CpuRst = 1;
    advance();
    advance();
    CpuRst = 0;
    repeat (TB_DRAIN) advance();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    CpuRst = 1;
    advance();
    @(negedge clk);
    n_checks++;
    if (dut_vec() !== 10'b00000_11111) begin
      n_errors++; $display("FAIL rst_hold got %b exp %b", dut_vec(), 10'b00000_11111);
    end
    advance();
    CpuRst = 0;
    for (int i = 0; i < TB_DRAIN; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== 10'b00000_11111) begin
        n_errors++; $display("FAIL drain_%0d got %b exp %b", i, dut_vec(), 10'b00000_11111);
      end
      n_checks++;
      if (StallCnt !== '0 || FlushCnt !== '0) begin
        n_errors++; $display("FAIL drain_cnt_%0d got %0d/%0d exp 0/0", i, StallCnt, FlushCnt);
      end
      advance();
    end
    @(negedge clk);
    n_checks++;
    if (dut_vec() !== 10'b0) begin
      n_errors++; $display("FAIL drain_end got %b exp %b", dut_vec(), 10'b0);
    end
    advance();
  endtask

  task automatic test_load_use();
    // {MemReadE, RdE, Rs1D, Rs2D, RegReadD, JalD, expected stall/flush}
    logic [28:0] tbl [0:6];
    int exp_s, exp_f;
    tbl = '{
      {1'b1, 5'd5, 5'd5, 5'd0, 2'b10, 1'b0, 10'b11000_00100},
      {1'b1, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0, 10'b00000_00000},
      {1'b1, 5'd7, 5'd0, 5'd7, 2'b01, 1'b0, 10'b11000_00100},
      {1'b1, 5'd7, 5'd7, 5'd3, 2'b01, 1'b0, 10'b00000_00000},
      {1'b0, 5'd5, 5'd5, 5'd5, 2'b11, 1'b0, 10'b00000_00000},
      {1'b1, 5'd6, 5'd6, 5'd0, 2'b10, 1'b1, 10'b11000_00100},
      {1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 10'b00000_01000}
    };
    do_reset();
    exp_s = 0; exp_f = 0;
    for (int i = 0; i < 7; i++) begin
      {MemReadE, RdE, Rs1D, Rs2D, RegReadD, JalD} = tbl[i][28:10];
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== tbl[i][9:0]) begin
        n_errors++; $display("FAIL lu_case%0d got %b exp %b", i, dut_vec(), tbl[i][9:0]);
      end
      n_checks++;
      if (StallCnt !== TB_CW'(exp_s) || FlushCnt !== TB_CW'(exp_f)) begin
        n_errors++; $display("FAIL lu_cnt%0d got %0d/%0d exp %0d/%0d", i, StallCnt, FlushCnt, exp_s, exp_f);
      end
      if (tbl[i][9:5] != 0) exp_s++;
      if (tbl[i][10] && tbl[i][9:5] == 0) exp_f++;
      advance();
    end
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (StallCnt !== 10'd3 || FlushCnt !== 10'd1) begin
      n_errors++; $display("FAIL lu_totals got %0d/%0d exp 3/1", StallCnt, FlushCnt);
    end
    advance();
  endtask

  task automatic test_dmiss();
    do_reset();
    DCacheMiss = 1; RedirectE = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== 10'b11110_00001) begin
        n_errors++; $display("FAIL dmiss_c%0d got %b exp %b", i, dut_vec(), 10'b11110_00001);
      end
      advance();
      RedirectE = 0;
    end
    DCacheMiss = 0;
    @(negedge clk);
    n_checks++;
    if (dut_vec() !== 10'b0) begin
      n_errors++; $display("FAIL dmiss_release got %b exp %b", dut_vec(), 10'b0);
    end
    n_checks++;
    if (StallCnt !== 10'd4 || FlushCnt !== 10'd0) begin
      n_errors++; $display("FAIL dmiss_cnt got %0d/%0d exp 4/0", StallCnt, FlushCnt);
    end
    advance();
  endtask

  task automatic test_imiss_redirect();
    logic [9:0] exp_v [0:4];
    bit im [0:4];
    bit re [0:4];
    exp_v = '{10'b10000_01000, 10'b10000_01100, 10'b10000_01000, 10'b00000_01000, 10'b0};
    im = '{1, 1, 1, 0, 0};
    re = '{0, 1, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ICacheMiss = im[i]; RedirectE = re[i];
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_v[i]) begin
        n_errors++; $display("FAIL imiss_c%0d got %b exp %b", i, dut_vec(), exp_v[i]);
      end
      advance();
    end
    @(negedge clk);
    n_checks++;
    if (FlushCnt !== 10'd1 || StallCnt !== 10'd3) begin
      n_errors++; $display("FAIL imiss_cnt got %0d/%0d exp 1/3", FlushCnt, StallCnt);
    end
    advance();
  endtask

  task automatic test_saturation();
    do_reset();
    DCacheMiss = 1;
    repeat (CNT_MAX - 1) advance();
    @(negedge clk);
    n_checks++;
    if (StallCnt !== TB_CW'(CNT_MAX - 1)) begin
      n_errors++; $display("FAIL sat_pre got %0d exp %0d", StallCnt, CNT_MAX - 1);
    end
    for (int i = 0; i < 3; i++) begin
      advance();
      @(negedge clk);
      n_checks++;
      if (StallCnt !== TB_CW'(CNT_MAX)) begin
        n_errors++; $display("FAIL sat_hold%0d got %0d exp %0d", i, StallCnt, CNT_MAX);
      end
    end
    advance();
    DCacheMiss = 0; JalD = 1;
    repeat (CNT_MAX + 2) advance();
    @(negedge clk);
    n_checks++;
    if (FlushCnt !== TB_CW'(CNT_MAX) || dut_vec() !== 10'b00000_01000) begin
      n_errors++; $display("FAIL flush_sat got %0d %b exp %0d %b", FlushCnt, dut_vec(), CNT_MAX, 10'b00000_01000);
    end
    advance();
    JalD = 0;
  endtask

  task automatic test_rst_in_dmiss();
    do_reset();
    DCacheMiss = 1;
    advance();
    CpuRst = 1;
    @(negedge clk);
    n_checks++;
    if (dut_vec() !== 10'b11110_00001) begin
      n_errors++; $display("FAIL rst_dmiss_pre got %b exp %b", dut_vec(), 10'b11110_00001);
    end
    advance();
    CpuRst = 0;
    @(negedge clk);
    n_checks++;
    if (dut_vec() !== 10'b00000_11111 || StallCnt !== '0) begin
      n_errors++; $display("FAIL rst_dmiss_drain got %b cnt %0d exp %b cnt 0", dut_vec(), StallCnt, 10'b00000_11111);
    end
    advance();
    DCacheMiss = 0;
  endtask

  task automatic test_random();
    bit dm, im;
    do_reset();
    dm = 0; im = 0;
    for (int i = 0; i < 1500; i++) begin
      CpuRst     = ($urandom_range(0, 149) == 0);
      dm         = dm ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 11) == 0);
      im         = im ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 6) == 0);
      DCacheMiss = dm;
      ICacheMiss = im;
      RedirectE  = ($urandom_range(0, 7) == 0);
      JalD       = ($urandom_range(0, 7) == 0);
      MemReadE   = ($urandom_range(0, 2) == 0);
      RdE        = 5'($urandom_range(0, 3));
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      RegReadD   = 2'($urandom_range(0, 3));
      @(negedge clk);
      model_eval();
      n_checks++;
      if (dut_vec() !== {e_stall, e_flush}) begin
        n_errors++; $display("FAIL rnd_vec cyc %0d got %b exp %b", i, dut_vec(), {e_stall, e_flush});
      end
      n_checks++;
      if (StallCnt !== TB_CW'(m_scnt)) begin
        n_errors++; $display("FAIL rnd_stallcnt cyc %0d got %0d exp %0d", i, StallCnt, m_scnt);
      end
      n_checks++;
      if (FlushCnt !== TB_CW'(m_fcnt)) begin
        n_errors++; $display("FAIL rnd_flushcnt cyc %0d got %0d exp %0d", i, FlushCnt, m_fcnt);
      end
      n_checks++;
      if (({StallF, StallD, StallE, StallM, StallW} & {FlushF, FlushD, FlushE, FlushM, FlushW}) !== 5'b0) begin
        n_errors++; $display("FAIL rnd_overlap cyc %0d got %b exp %b", i, dut_vec(), 10'b0);
      end
      advance();
    end
    CpuRst = 0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    CpuRst = 1;
    test_reset();
    test_load_use();
    test_dmiss();
    test_imiss_redirect();
    test_rst_in_dmiss();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
